fetch_window_unit: RTL and testbench

//  Fetch-side initiator for the dual-window instruction memory port. Issues the window

---
 rtl/fetch_window_unit_pkg.sv | 32 +++
 rtl/fetch_window_unit_queue.sv | 60 ++++++
 rtl/fetch_window_unit.sv | 139 +++++++++++++
 tb/tb_fetch_window_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_window_unit_pkg.sv
// Shared types and helpers for the dual-window fetch unit: pair payload, FSM states
// and the PC/window arithmetic used by the address path.
package fetch_window_unit_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          WINDOW_W     = 128;
    localparam logic [31:0] PAIR_STRIDE  = 32'd8;
    localparam logic [31:0] WINDOW_BYTES = 32'd16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instrA;
        logic [31:0] instrB;
        logic        misaligned;
    } FetchPair;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_HALT
    } FetchState;

    function automatic logic [31:0] window_base(input logic [31:0] pc);
        return {pc[31:4], 4'h0};
    endfunction

    // Modulo-2^32 step to the next pair; 32'hFFFF_FFF8 wraps to 0.
    function automatic logic [31:0] pair_step(input logic [31:0] pc);
        return pc + PAIR_STRIDE;
    endfunction

endpackage

// File: rtl/fetch_window_unit_queue.sv
// Small power-of-two FIFO of fetch pairs with synchronous flush; head is read
// straight from the storage registers so the outputs toward decode are registered.
module fetch_pair_queue
    import fetch_window_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  FetchPair               push_data,
    output FetchPair               head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    FetchPair        storage [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            empty;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // At full, a same-cycle pop frees the slot being written.
    assign push_ok = push && (!full || pop_ok);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_window_unit.sv
// Fetch-side initiator: drives the two window addresses, extracts the instruction
// pair at mPc from the returned 256-bit line and queues it toward decode.
module fetch_window_unit
    import fetch_window_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                redirect,
    input  logic [31:0]         redirectVector,
    output logic [31:0]         readAddressA,
    output logic [31:0]         readAddressB,
    input  logic [WINDOW_W-1:0] readDataA,
    input  logic [WINDOW_W-1:0] readDataB,
    output logic                fetchValid,
    input  logic                fetchReady,
    output logic [31:0]         fetchPc,
    output logic [31:0]         fetchInstrA,
    output logic [31:0]         fetchInstrB,
    output logic                fetchMisaligned
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    FetchState     state;
    FetchState     state_next;
    logic          m_valid;
    logic          m_valid_next;
    logic [31:0]   m_pc;
    logic [31:0]   m_pc_next;
    logic [31:0]   next_pc;

    logic          push;
    logic          pop;
    logic          has_space;
    logic [CW-1:0] q_count;
    FetchPair      q_head;
    FetchPair      pair_in;

    logic [2*WINDOW_W-1:0] line;
    logic [7:0]            sel_a;
    logic [7:0]            sel_b;
    logic                  misaligned;

    // Extraction: word k of the line is instrA, word k+1 may come from window B.
    assign line       = {readDataB, readDataA};
    assign sel_a      = {1'b0, m_pc[3:2], 5'b0};
    assign sel_b      = sel_a + 8'd32;
    assign misaligned = (m_pc[1:0] != 2'b00);

    always_comb begin
        pair_in            = '0;
        pair_in.pc         = m_pc;
        pair_in.misaligned = misaligned;
        if (!misaligned) begin
            pair_in.instrA = line[sel_a +: INSTR_W];
            pair_in.instrB = line[sel_b +: INSTR_W];
        end
    end

    assign pop       = fetchValid && fetchReady;
    assign has_space = (q_count < CW'(QUEUE_DEPTH));
    assign push      = (state == FETCH_RUN) && m_valid && !redirect && (has_space || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= FETCH_BOOT;
            m_valid <= 1'b0;
            m_pc    <= RESET_VECTOR;
        end else begin
            state   <= state_next;
            m_valid <= m_valid_next;
            m_pc    <= m_pc_next;
        end
    end

    // Without a push the current window is re-presented so the same line returns.
    always_comb begin
        state_next   = state;
        m_valid_next = m_valid;
        m_pc_next    = m_pc;
        next_pc      = m_pc;
        case (state)
            FETCH_BOOT: begin
                next_pc      = RESET_VECTOR;
                state_next   = FETCH_RUN;
                m_valid_next = 1'b1;
                m_pc_next    = RESET_VECTOR;
            end
            FETCH_RUN: begin
                if (push) begin
                    next_pc   = pair_step(m_pc);
                    m_pc_next = pair_step(m_pc);
                    if (misaligned) begin
                        state_next   = FETCH_HALT;
                        m_valid_next = 1'b0;
                    end
                end
            end
            FETCH_HALT: begin
                m_valid_next = 1'b0;
            end
            default: begin
                state_next   = FETCH_BOOT;
                m_valid_next = 1'b0;
            end
        endcase
        if (redirect) begin
            state_next   = FETCH_RUN;
            m_valid_next = 1'b1;
            m_pc_next    = redirectVector;
        end
    end

    assign readAddressA = window_base(next_pc);
    assign readAddressB = readAddressA + WINDOW_BYTES;

    fetch_pair_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .pop       (pop),
        .push_data (pair_in),
        .head      (q_head),
        .count     (q_count)
    );

    assign fetchValid      = (q_count != '0);
    assign fetchPc         = q_head.pc;
    assign fetchInstrA     = q_head.instrA;
    assign fetchInstrB     = q_head.instrB;
    assign fetchMisaligned = q_head.misaligned;

endmodule

// File: tb/tb_fetch_window_unit.sv
// Directed bench for fetch_window_unit with a behavioural dual-window memory whose
// words encode their own byte address.
module tb_fetch_window_unit;

    logic         clock;
    logic         reset;
    logic         redirect;
    logic [31:0]  redirectVector;
    logic [31:0]  readAddressA;
    logic [31:0]  readAddressB;
    logic [127:0] readDataA;
    logic [127:0] readDataB;
    logic         fetchValid;
    logic         fetchReady;
    logic [31:0]  fetchPc;
    logic [31:0]  fetchInstrA;
    logic [31:0]  fetchInstrB;
    logic         fetchMisaligned;

    int passed = 0;
    int total  = 0;

    fetch_window_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .QUEUE_DEPTH  (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .redirectVector  (redirectVector),
        .readAddressA    (readAddressA),
        .readAddressB    (readAddressB),
        .readDataA       (readDataA),
        .readDataB       (readDataB),
        .fetchValid      (fetchValid),
        .fetchReady      (fetchReady),
        .fetchPc         (fetchPc),
        .fetchInstrA     (fetchInstrA),
        .fetchInstrB     (fetchInstrB),
        .fetchMisaligned (fetchMisaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[23:8] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [127:0] window_at(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0};
        return {word_at(b + 32'd12), word_at(b + 32'd8), word_at(b + 32'd4), word_at(b)};
    endfunction

    // Memory: 1-cycle latency, self-addresses to the redirect vector on redirect.
    always @(posedge clock) begin
        if (redirect) begin
            readDataA <= window_at(redirectVector);
            readDataB <= window_at(redirectVector + 32'd16);
        end else begin
            readDataA <= window_at(readAddressA);
            readDataB <= window_at(readAddressB);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] vec);
        @(negedge clock);
        fetchReady     = rdy;
        redirect       = redir;
        redirectVector = vec;
        #1;
    endtask

    task automatic chk_pair(input string name, input logic [31:0] pc);
        logic mis;
        mis = (pc[1:0] != 2'b00);
        chk({name, " valid"}, {31'b0, fetchValid}, 32'd1);
        chk({name, " pc"}, fetchPc, pc);
        chk({name, " instrA"}, fetchInstrA, mis ? 32'h0 : word_at(pc));
        chk({name, " instrB"}, fetchInstrB, mis ? 32'h0 : word_at(pc + 32'd4));
        chk({name, " misaligned"}, {31'b0, fetchMisaligned}, {31'b0, mis});
    endtask

    typedef struct {
        logic        rdy;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } boot_vec_t;

    boot_vec_t boot_tbl [6];

    task automatic run_boot_table();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) reset = 1'b1;
            fetchReady     = boot_tbl[i].rdy;
            redirect       = 1'b0;
            redirectVector = 32'h0;
            #1;
            chk($sformatf("boot%0d addrA", i), readAddressA, boot_tbl[i].addr);
            chk($sformatf("boot%0d addrB", i), readAddressB, boot_tbl[i].addr + 32'd16);
            chk($sformatf("boot%0d valid", i), {31'b0, fetchValid}, {31'b0, boot_tbl[i].vld});
            if (boot_tbl[i].vld) chk_pair($sformatf("boot%0d", i), boot_tbl[i].pc);
        end
    endtask

    initial begin
        boot_tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h00};
        boot_tbl[1] = '{1'b1, 32'h00, 1'b0, 32'h00};
        boot_tbl[2] = '{1'b1, 32'h10, 1'b1, 32'h00};
        boot_tbl[3] = '{1'b1, 32'h10, 1'b1, 32'h08};
        boot_tbl[4] = '{1'b1, 32'h20, 1'b1, 32'h10};
        boot_tbl[5] = '{1'b1, 32'h20, 1'b1, 32'h18};

        reset          = 1'b0;
        redirect       = 1'b0;
        redirectVector = 32'h0;
        fetchReady     = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset valid", {31'b0, fetchValid}, 32'd0);
        chk("reset pc", fetchPc, 32'h0);
        chk("reset instrA", fetchInstrA, 32'h0);
        chk("reset misaligned", {31'b0, fetchMisaligned}, 32'd0);
        chk("reset addrA", readAddressA, 32'h0);

        // Scenario 1: boot stream.
        run_boot_table();

        // Scenario 2: redirect into the last word of a window (straddle).
        cyc(1'b1, 1'b1, 32'h1C);
        cyc(1'b1, 1'b0, 32'h0);
        chk("redir1C flushed", {31'b0, fetchValid}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("straddle", 32'h1C);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("after straddle", 32'h24);

        // Scenario 3: backpressure fills the queue, then drains without a gap.
        cyc(1'b0, 1'b1, 32'h20);
        cyc(1'b0, 1'b0, 32'h0);
        chk("bp empty", {31'b0, fetchValid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk($sformatf("bp%0d addrA", i), readAddressA, 32'h30);
            chk($sformatf("bp%0d head pc", i), fetchPc, 32'h20);
            chk($sformatf("bp%0d valid", i), {31'b0, fetchValid}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk_pair($sformatf("drain%0d", i), 32'h20 + 32'(i * 8));
        end

        // Scenario 4: redirect coinciding with a pop.
        cyc(1'b1, 1'b1, 32'h300);
        chk("pop+redir valid", {31'b0, fetchValid}, 32'd1);
        cyc(1'b1, 1'b0, 32'h0);
        chk("pop+redir flushed", {31'b0, fetchValid}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("redir300", 32'h300);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("redir308", 32'h308);

        // Scenario 5: misaligned redirect halts after one flagged pair.
        cyc(1'b1, 1'b1, 32'h102);
        cyc(1'b1, 1'b0, 32'h0);
        chk("mis flushed", {31'b0, fetchValid}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("misaligned", 32'h102);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk($sformatf("halt%0d valid", i), {31'b0, fetchValid}, 32'd0);
        end
        cyc(1'b1, 1'b1, 32'h200);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_pair("resume200", 32'h200);

        // Scenario 6: async reset with a full queue, then a clean reboot.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("full before reset", {31'b0, fetchValid}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async reset valid", {31'b0, fetchValid}, 32'd0);
        chk("async reset pc", fetchPc, 32'h0);
        chk("async reset addrA", readAddressA, 32'h0);
        repeat (2) @(negedge clock);
        run_boot_table();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
